// File: rtl/fp_argmin_seq_if.sv
// fp_argmin_seq_if: candidate stream in, min result out; m_cnt present only with FP_ARGMIN_SEQ_CNT_EN
interface fp_argmin_seq_if #(
   parameter int DW = 32,
   parameter int IW = 4
) ();
   logic          s_vld;
   logic          s_rdy;
   logic          s_last;
   logic [IW-1:0] s_idx;
   logic [DW-1:0] s_dat;
   logic          m_vld;
   logic          m_rdy;
   logic [IW-1:0] m_idx;
   logic [DW-1:0] m_dat;
`ifdef FP_ARGMIN_SEQ_CNT_EN
   logic [IW:0]   m_cnt;
`endif
   modport slave (
      input  s_vld, s_last, s_idx, s_dat, m_rdy,
      output s_rdy, m_vld, m_idx, m_dat
`ifdef FP_ARGMIN_SEQ_CNT_EN
      , output m_cnt
`endif
   );
   modport master (
      output s_vld, s_last, s_idx, s_dat, m_rdy,
      input  s_rdy, m_vld, m_idx, m_dat
`ifdef FP_ARGMIN_SEQ_CNT_EN
      , input m_cnt
`endif
   );
endinterface

// File: rtl/fp_argmin_seq.sv
// fp_argmin_seq: sequential FP arg-min over a candidate set using NL=LAT+1 lanes and one shared compare unit; FP_ARGMIN_SEQ_CNT_EN adds m_cnt
module fp_argmin_seq #(
   parameter int DW  = 32,
   parameter int IW  = 4,
   parameter int LAT = 1
) (
   input  logic             clk,
   input  logic             rstn,
   fp_argmin_seq_if.slave   bus,
   output logic             busy
);
   localparam int NL = LAT + 1;
   localparam int LW = $clog2(NL);
   typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, REDUCE, OUT} st_t;
   typedef struct packed {
      logic          v;
      logic [LW-1:0] l;
      logic [IW-1:0] i;
      logic [DW-1:0] d;
   } res_t;
   st_t           st;
   logic          rdy, vld, xfer;
   logic [LW-1:0] lp, sub, fl;
   logic [NL-1:0] lv;
   logic [IW-1:0] li [NL];
   logic [DW-1:0] ld [NL];
   res_t          iss, wb;
`ifdef FP_ARGMIN_SEQ_CNT_EN
   logic [IW:0]   cnt;
   assign bus.m_cnt = cnt;
`endif
   assign xfer      = bus.s_vld & rdy;
   assign bus.s_rdy = rdy;
   assign bus.m_vld = vld;
   assign bus.m_idx = li[0];
   assign bus.m_dat = ld[0];

   // sign of the exact difference a-b; an IEEE subtract of finite values is zero only when a==b
   function automatic logic lt_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (a[DW-2:0] == '0 && b[DW-2:0] == '0) return 1'b0;
      if (a[DW-1] != b[DW-1]) return a[DW-1];
      return a[DW-1] ? a[DW-2:0] > b[DW-2:0] : a[DW-2:0] < b[DW-2:0];
   endfunction

   function automatic logic eq_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return a == b || (a[DW-2:0] == '0 && b[DW-2:0] == '0);
   endfunction

   // negative difference keeps x, zero keeps the lower index, otherwise y
   function automatic res_t pick(input logic [LW-1:0] l, input logic [IW-1:0] xi, input logic [DW-1:0] xd,
                                 input logic [IW-1:0] yi, input logic [DW-1:0] yd);
      logic x;
      x = lt_f(xd, yd) || (eq_f(xd, yd) && xi < yi);
      return '{v: 1'b1, l: l, i: x ? xi : yi, d: x ? xd : yd};
   endfunction

   // compare issue: candidate against its occupied lane, or a reduce fold of lane fl into lane 0
   always_comb begin
      iss = (xfer && lv[lp]) ? pick(lp, bus.s_idx, bus.s_dat, li[lp], ld[lp]) :
            (st == REDUCE && sub == '0 && lv[fl]) ? pick('0, li[fl], ld[fl], li[0], ld[0]) : '0;
   end

   // the lane register is the last of the LAT stages, so a result is visible LAT cycles after issue
   generate
      if (LAT == 1) begin : g_direct
         assign wb = iss;
      end else begin : g_pipe
         res_t pipe [LAT-1];
         // delay line carrying the selected result towards its lane
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) pipe <= '{default: '0};
            else begin
               pipe[0] <= iss;
               for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
            end
         end
         assign wb = pipe[LAT-2];
      end
   endgenerate

   // lane storage: direct load into empty lanes, compare write-back, cleared once the result is taken
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lv <= '0;
         li <= '{default: '0};
         ld <= '{default: '0};
      end else if (st == OUT && bus.m_rdy) begin
         lv <= '0;
      end else begin
         if (xfer && !lv[lp]) begin
            lv[lp] <= 1'b1;
            li[lp] <= bus.s_idx;
            ld[lp] <= bus.s_dat;
         end
         if (wb.v) begin
            li[wb.l] <= wb.i;
            ld[wb.l] <= wb.d;
         end
      end
   end

   // control FSM with registered handshake and busy outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st   <= IDLE;
         rdy  <= 1'b1;
         vld  <= 1'b0;
         busy <= 1'b0;
         lp   <= '0;
         sub  <= '0;
         fl   <= '0;
`ifdef FP_ARGMIN_SEQ_CNT_EN
         cnt  <= '0;
`endif
      end else begin
         case (st)
            IDLE, ACCUM: if (xfer) begin
               busy <= 1'b1;
`ifdef FP_ARGMIN_SEQ_CNT_EN
               cnt  <= (st == IDLE) ? (IW+1)'(1) : &cnt ? cnt : cnt + 1'b1;
`endif
               if (bus.s_last) begin
                  st  <= DRAIN;
                  rdy <= 1'b0;
                  lp  <= '0;
                  sub <= '0;
               end else begin
                  st <= ACCUM;
                  lp <= (lp == LW'(NL - 1)) ? '0 : lp + 1'b1;
               end
            end
            DRAIN: if (sub == LW'(LAT - 1)) begin
               st  <= REDUCE;
               sub <= '0;
               fl  <= LW'(1);
            end else sub <= sub + 1'b1;
            REDUCE: if (sub == LW'(LAT - 1)) begin
               sub <= '0;
               if (fl == LW'(LAT)) begin
                  st  <= OUT;
                  vld <= 1'b1;
               end else fl <= fl + 1'b1;
            end else sub <= sub + 1'b1;
            OUT: if (bus.m_rdy) begin
               st   <= IDLE;
               vld  <= 1'b0;
               rdy  <= 1'b1;
               busy <= 1'b0;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_argmin_seq.sv
// tb_fp_argmin_seq: directed checks of fp_argmin_seq (LAT=1) against hand-computed minima
module tb_fp_argmin_seq;
   localparam int LAT  = 1;
   localparam int ELAT = LAT * (LAT + 1) + 1;
   logic clk, rstn, busy;
   int   n_chk = 0, n_fail = 0;
   logic [3:0]  vi [8];
   logic [31:0] vd [8];

   fp_argmin_seq_if #(.DW(32), .IW(4)) bus ();
   fp_argmin_seq #(.DW(32), .IW(4), .LAT(LAT)) dut (.clk(clk), .rstn(rstn), .bus(bus), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] i, input logic [31:0] d, input logic l, input int gap);
      int n = 0;
      bus.s_vld = 1'b1;
      bus.s_idx = i;
      bus.s_dat = d;
      bus.s_last = l;
      while (!bus.s_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send.s_rdy", 32'(bus.s_rdy), 1);
      @(posedge clk);
      @(negedge clk);
      bus.s_vld = 1'b0;
      bus.s_last = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic play(input int n, input int gap);
      for (int k = 0; k < n; k++) send(vi[k], vd[k], k == n - 1, k == n - 1 ? 0 : gap);
   endtask

   task automatic result(input string tag, input logic [3:0] ei, input logic [31:0] ed, input int ec);
      int lat = 1;
      while (!bus.m_vld && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(ELAT));
      check({tag, ".idx"}, 32'(bus.m_idx), 32'(ei));
      check({tag, ".dat"}, bus.m_dat, ed);
`ifdef FP_ARGMIN_SEQ_CNT_EN
      check({tag, ".cnt"}, 32'(bus.m_cnt), 32'(ec));
`endif
      if (bus.m_rdy) begin
         @(negedge clk);
         check({tag, ".vld_clr"}, 32'(bus.m_vld), 0);
         check({tag, ".rdy_set"}, 32'(bus.s_rdy), 1);
      end
   endtask

   task automatic load_basic();
      vi = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
      vd = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F000000, 0, 0, 0, 0};
   endtask

   task automatic load_tie();
      vi = '{4'd5, 4'd2, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      vd = '{32'h40000000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 0, 0};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      bus.s_vld = 1'b0;
      bus.s_last = 1'b0;
      bus.s_idx = '0;
      bus.s_dat = '0;
      bus.m_rdy = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.m_vld", 32'(bus.m_vld), 0);
      check("rst.m_idx", 32'(bus.m_idx), 0);
      check("rst.m_dat", bus.m_dat, 0);
      check("rst.busy", 32'(busy), 0);
      check("rst.s_rdy", 32'(bus.s_rdy), 1);
      rstn = 1'b1;
      @(negedge clk);

      load_basic();
      play(4, 0);
      result("basic", 4'd3, 32'h3F000000, 4);

      load_tie();
      play(3, 0);
      result("tie", 4'd2, 32'h3F800000, 3);

      vi[0] = 4'd9;
      vd[0] = 32'hBFC00000;
      play(1, 0);
      result("single", 4'd9, 32'hBFC00000, 1);

      vi = '{4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      vd = '{32'h80000000, 32'h00000000, 0, 0, 0, 0, 0, 0};
      play(2, 0);
      result("zero", 4'd1, 32'h00000000, 2);

      vi = '{4'd4, 4'd1, 4'd6, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};
      vd = '{32'h80000000, 32'h00000000, 32'hC0000000, 32'hBF800000, 0, 0, 0, 0};
      play(4, 0);
      result("neg", 4'd6, 32'hC0000000, 4);

      bus.m_rdy = 1'b0;
      load_basic();
      play(4, 0);
      result("bp", 4'd3, 32'h3F000000, 4);
      repeat (5) begin
         @(negedge clk);
         check("bp.m_vld", 32'(bus.m_vld), 1);
         check("bp.m_idx", 32'(bus.m_idx), 3);
         check("bp.m_dat", bus.m_dat, 32'h3F000000);
         check("bp.s_rdy", 32'(bus.s_rdy), 0);
         check("bp.busy", 32'(busy), 1);
      end
      bus.m_rdy = 1'b1;
      @(negedge clk);
      check("bp.rel_vld", 32'(bus.m_vld), 0);
      check("bp.rel_rdy", 32'(bus.s_rdy), 1);
      check("bp.rel_busy", 32'(busy), 0);
      load_tie();
      play(3, 0);
      result("bp2", 4'd2, 32'h3F800000, 3);

      load_basic();
      play(4, 2);
      result("gap", 4'd3, 32'h3F000000, 4);

      load_basic();
      play(4, 0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("rr.m_vld", 32'(bus.m_vld), 0);
      check("rr.s_rdy", 32'(bus.s_rdy), 1);
      check("rr.busy", 32'(busy), 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("rr.no_out", 32'(bus.m_vld), 0);
      end
      load_tie();
      play(3, 0);
      result("rr.fresh", 4'd2, 32'h3F800000, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_argmin_seq.md
Name: fp_argmin_seq

Overview:
- Sequential arg-min engine for the quantizer's nearest-centroid search.
- Accepts a stream of (index, FP distance) candidates and time-shares one pipelined FP subtract/compare unit across them.
- Emits the minimum distance and its index once per candidate set.
- Sits between the distance-computation pipeline and the hierarchical codebook walker, replacing a tree of parallel min cells.

Parameters:
- DW, 32, distance data width (IEEE single).
- IW, 4, candidate index width.
- LAT, 1, register stages of the FP subtract unit (LAT >= 1); lane count NL = LAT+1.

Ports:
- clk  input  1  global clock.
- rstn  input  1  asynchronous active-low reset.
- s_vld  input  1  candidate valid.
- s_rdy  output  1  candidate ready.
- s_last  input  1  marks final candidate of the set.
- s_idx  input  IW  candidate index.
- s_dat  input  DW  candidate distance.
- m_vld  output  1  result valid.
- m_rdy  input  1  result ready.
- m_idx  output  IW  index of the minimum.
- m_dat  output  DW  minimum distance.
- busy  output  1  set in progress (any state except IDLE).

Behaviour:
- Reset (rstn low, async): state IDLE, all lane valid bits cleared, pipeline valids cleared. m_vld=0, m_idx=0, m_dat=0, busy=0, s_rdy=1.
- States: IDLE, ACCUM, DRAIN, REDUCE, OUT.
- s_rdy=1 only in IDLE/ACCUM. A transfer occurs when s_vld&s_rdy.
- IDLE: on transfer -> ACCUM. If s_last is also set -> DRAIN.
- ACCUM:
  - Transfer k of the set targets lane (k mod NL). The lane pointer advances only on transfer.
  - If the target lane is invalid, the candidate loads directly and the lane valid bit is set.
  - Otherwise (candidate, lane) issue to the compare unit. The result writes back to that lane LAT cycles later.
  - Gaps on s_vld are legal; they only delay lane reuse.
  - A transfer with s_last -> DRAIN.
- DRAIN: wait LAT cycles for in-flight compares -> REDUCE.
- REDUCE:
  - Fold lanes 1..NL-1 into lane 0 in order, one fold per LAT cycles, no overlap.
  - Invalid lanes are skipped by select but still consume their slot, so latency is fixed.
  - After the last fold -> OUT.
- Selection rule (both phases): compare x-y via the FP subtract.
  - Sign 1: pick x.
  - Result exactly zero: pick the smaller index.
  - Otherwise: pick y.
  - Net effect: minimum data, lowest index on ties. NaN inputs are undefined.
- Latency: m_vld rises exactly LAT*(LAT+1)+1 cycles after the s_last transfer cycle (3 for LAT=1).
- OUT: m_vld=1; m_idx and m_dat held stable until m_rdy. On m_vld&m_rdy -> IDLE, lanes cleared, s_rdy=1 the next cycle.
- Reset mid-operation aborts the set immediately; no partial result is emitted.

Optional Feature:
- Macro FP_ARGMIN_SEQ_CNT_EN.
- Defined: adds output m_cnt [IW:0], the number of candidates transferred in the set. Valid with m_vld, reset 0, saturates at 2^(IW+1)-1.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Basic, LAT=1: idx0..3 with data 0x40400000, 0x3F800000, 0x40000000, 0x3F000000, s_last on idx3 -> m_idx=3, m_dat=0x3F000000, m_vld exactly 3 cycles after the last transfer; with CNT_EN, m_cnt=4.
- Tie: idx5=0x40000000, idx2=0x3F800000, idx7=0x3F800000 (lanes 0/1/0) -> m_idx=2, m_dat=0x3F800000.
- Single candidate: idx9=0xBFC00000 with s_last -> m_idx=9, m_dat=0xBFC00000, same fixed latency.
- Backpressure: the basic set with m_rdy low for 5 cycles -> m_vld/m_idx/m_dat stable, s_rdy=0, busy=1. Release -> s_rdy=1 the next cycle and a second set is accepted correctly.
- Input gaps: the basic set with 2 idle s_vld cycles between every item -> same result as the basic test.
- Reset during REDUCE: assert rstn low for 1 cycle -> m_vld=0, s_rdy=1, busy=0. A following fresh set returns the correct min.
